// File: rtl/frame_rd_stream_if.sv
// Frame-buffer read port bundle: request/address out, read data back.
// The stream stage owns the master side.
interface frame_rd_stream_if;
  logic        avl_read_req;
  logic [28:0] avl_addr;
  logic        avl_ready;
  logic [31:0] rd_data;
  logic        rd_data_valid;

  modport master (
    output avl_read_req,
    output avl_addr,
    input  avl_ready,
    input  rd_data,
    input  rd_data_valid
  );

  modport slave (
    input  avl_read_req,
    input  avl_addr,
    output avl_ready,
    output rd_data,
    output rd_data_valid
  );
endinterface

// File: rtl/frame_rd_stream.sv
// Frame read-out stage: credit-managed prefetch FIFO feeding the HDMI pixel bus.
// Define FRAME_RD_UNDERFLOW_MARK_EN to emit magenta on underflow cycles.
module frame_rd_stream #(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter logic [28:0] BASE_ADDR  = 29'd0,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ram_rdy,
  frame_rd_stream_if.master           bus,
  input  logic                        frame_start,
  input  logic                        vid_de,
  output logic [23:0]                 pix_data,
  output logic                        underflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [28:0] LAST_ADDR =
    BASE_ADDR + 29'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [LW:0] DEPTH_W = (LW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH
  } state_t;

  state_t state, state_nxt;

  logic [LW-1:0] outst, outst_nxt;
  logic [LW-1:0] drop_cnt, drop_nxt;
  logic [LW-1:0] lvl_nxt;
  logic [LW:0]   credit_sum;
  logic          req_nxt;
  logic [28:0]   addr_nxt;
  logic          reload_pend, reload_nxt;
  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          acc, hold, ret, push, pop;
  logic          empty, full, uflow, dropping;
  logic          unused_hi;

  assign unused_hi = ^bus.rd_data[31:24];

  assign acc      = bus.avl_read_req & bus.avl_ready;
  assign hold     = bus.avl_read_req & ~bus.avl_ready;
  assign ret      = bus.rd_data_valid & (outst != '0);
  assign dropping = ret & (drop_cnt != '0);
  assign empty    = (fifo_level == '0);
  assign full     = (fifo_level == LW'(FIFO_DEPTH));
  assign pop      = vid_de & ~empty;
  assign uflow    = vid_de & empty;
  // a word landing in the frame_start cycle belongs to the old frame
  assign push     = ret & (drop_cnt == '0) & ~frame_start;

  assign outst_nxt = outst + LW'(acc) - LW'(ret);
  assign lvl_nxt   = frame_start ? '0 :
                     fifo_level + LW'(push) - LW'(pop);
  assign drop_nxt  = frame_start ? outst_nxt :
                     drop_cnt - LW'(dropping);
  assign credit_sum = {1'b0, outst_nxt} + {1'b0, lvl_nxt};

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (frame_start && drop_nxt != '0)
          state_nxt = FLUSH;
        else if (ram_rdy)
          state_nxt = FETCH;
      end
      FETCH: begin
        if (frame_start && drop_nxt != '0)
          state_nxt = FLUSH;
        else if (!ram_rdy && !hold)
          state_nxt = IDLE;
      end
      FLUSH: begin
        if (drop_nxt == '0)
          state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_nxt = hold |
      ((state_nxt == FETCH) & ram_rdy &
       (credit_sum < DEPTH_W));
    addr_nxt   = bus.avl_addr;
    reload_nxt = reload_pend;
    if (acc) begin
      reload_nxt = 1'b0;
      if (frame_start || reload_pend ||
          bus.avl_addr == LAST_ADDR)
        addr_nxt = BASE_ADDR;
      else
        addr_nxt = bus.avl_addr + 29'd1;
    end else if (frame_start) begin
      // a held request keeps its address; reload after it goes
      if (bus.avl_read_req) reload_nxt = 1'b1;
      else                  addr_nxt   = BASE_ADDR;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.avl_read_req <= 1'b0;
      bus.avl_addr     <= BASE_ADDR;
      reload_pend      <= 1'b0;
      outst            <= '0;
      drop_cnt         <= '0;
      fifo_level       <= '0;
      wptr             <= '0;
      rptr             <= '0;
      pix_data         <= '0;
      underflow        <= 1'b0;
    end else begin
      bus.avl_read_req <= req_nxt;
      bus.avl_addr     <= addr_nxt;
      reload_pend      <= reload_nxt;
      outst            <= outst_nxt;
      drop_cnt         <= drop_nxt;
      fifo_level       <= lvl_nxt;
      if (frame_start) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
      end
      if (pop)
        pix_data <= mem[rptr];
`ifdef FRAME_RD_UNDERFLOW_MARK_EN
      else if (uflow)
        pix_data <= 24'hFF00FF;
`endif
      if (uflow) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.rd_data[23:0];
  end

  a_no_push_full: assert property (
    @(posedge clk) disable iff (!reset)
    !(push && full));

endmodule

// File: tb/tb_frame_rd_stream.sv
// Bench for frame_rd_stream: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_frame_rd_stream;

  localparam int          H = 4;
  localparam int          V = 2;
  localparam int          DEPTH = 4;
  localparam logic [28:0] BASE = 29'h100;
  localparam logic [28:0] LAST = BASE + 29'(H * V - 1);

  logic        clk;
  logic        reset;
  logic        ram_rdy;
  logic        frame_start;
  logic        vid_de;
  logic [23:0] pix_data;
  logic        underflow;
  logic [2:0]  fifo_level;

  frame_rd_stream_if bus ();

  frame_rd_stream #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ram_rdy     (ram_rdy),
    .bus         (bus),
    .frame_start (frame_start),
    .vid_de      (vid_de),
    .pix_data    (pix_data),
    .underflow   (underflow),
    .fifo_level  (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_req;
  logic [28:0] m_addr;
  bit          m_reload;
  int          m_mode;
  bit          inflight[$];
  logic [23:0] mfifo[$];
  logic [23:0] m_pix;
  bit          m_uf;
  logic [23:0] rq[$];
  bit          use_rand_px;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    bit acc, hold, ret, tag;
    int drops;
    if (!reset) begin
      m_req = 0;
      m_addr = BASE;
      m_reload = 0;
      m_mode = 0;
      inflight.delete();
      mfifo.delete();
      m_pix = '0;
      m_uf = 0;
      return;
    end
    acc  = m_req && bus.avl_ready;
    hold = m_req && !bus.avl_ready;
    ret  = bus.rd_data_valid && inflight.size() > 0;
    if (vid_de) begin
      if (mfifo.size() > 0) m_pix = mfifo.pop_front();
      else begin
        m_uf = 1;
`ifdef FRAME_RD_UNDERFLOW_MARK_EN
        m_pix = 24'hFF00FF;
`endif
      end
    end
    if (ret) begin
      tag = inflight.pop_front();
      if (!tag && !frame_start)
        mfifo.push_back(bus.rd_data[23:0]);
    end
    if (acc) begin
      rq.push_back(use_rand_px ? 24'($urandom) : m_addr[23:0]);
      inflight.push_back(1'b0);
    end
    if (frame_start) begin
      mfifo.delete();
      foreach (inflight[i]) inflight[i] = 1'b1;
    end
    if (acc) begin
      if (frame_start || m_reload || m_addr == LAST) m_addr = BASE;
      else m_addr = m_addr + 29'd1;
      m_reload = 0;
    end else if (frame_start) begin
      if (m_req) m_reload = 1;
      else m_addr = BASE;
    end
    drops = 0;
    foreach (inflight[i]) if (inflight[i]) drops++;
    case (m_mode)
      0: if (frame_start && drops > 0) m_mode = 2;
         else if (ram_rdy) m_mode = 1;
      1: if (frame_start && drops > 0) m_mode = 2;
         else if (!ram_rdy && !hold) m_mode = 0;
      default: if (drops == 0) m_mode = 1;
    endcase
    m_req = hold || (m_mode == 1 && ram_rdy &&
                     inflight.size() + mfifo.size() < DEPTH);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("model",
        {6'd0, bus.avl_read_req, bus.avl_addr, pix_data,
         underflow, fifo_level},
        {6'd0, m_req, m_addr, m_pix, m_uf,
         3'(mfifo.size())});
  endtask

  task automatic resp(input bit go);
    if (go && rq.size() > 0) begin
      bus.rd_data_valid = 1'b1;
      bus.rd_data = {8'($urandom), rq.pop_front()};
    end else begin
      bus.rd_data_valid = 1'b0;
      bus.rd_data = $urandom;
    end
  endtask

  typedef struct {
    bit          rst_n;
    bit          rdy;
    bit          ar;
    bit          exp_req;
    logic [28:0] exp_addr;
  } vec_t;

  vec_t vt[10];

  initial begin
    int npop, nret, k;
    bit wrap_seen, done;
    logic [28:0] a0, prev_acc;

    vt[0] = '{0, 0, 0, 0, 29'h100};
    vt[1] = '{0, 0, 0, 0, 29'h100};
    vt[2] = '{0, 0, 0, 0, 29'h100};
    vt[3] = '{1, 0, 0, 0, 29'h100};
    vt[4] = '{1, 1, 1, 1, 29'h100};
    vt[5] = '{1, 1, 1, 1, 29'h101};
    vt[6] = '{1, 1, 1, 1, 29'h102};
    vt[7] = '{1, 1, 1, 1, 29'h103};
    vt[8] = '{1, 1, 1, 0, 29'h104};
    vt[9] = '{1, 1, 1, 0, 29'h104};

    use_rand_px = 0;
    reset = 0;
    ram_rdy = 0;
    frame_start = 0;
    vid_de = 0;
    bus.avl_ready = 0;
    bus.rd_data_valid = 0;
    bus.rd_data = '0;

    // reset and initial credit fill
    for (int i = 0; i < 10; i++) begin
      reset = vt[i].rst_n;
      ram_rdy = vt[i].rdy;
      bus.avl_ready = vt[i].ar;
      resp(0);
      cycle();
      chk($sformatf("t1_req[%0d]", i), 64'(bus.avl_read_req),
          64'(vt[i].exp_req));
      chk($sformatf("t1_addr[%0d]", i), 64'(bus.avl_addr),
          64'(vt[i].exp_addr));
      chk($sformatf("t1_out[%0d]", i),
          {pix_data, underflow, fifo_level}, 64'd0);
    end

    // eight returns with data = address, streamed out
    npop = 0;
    nret = 0;
    wrap_seen = 0;
    prev_acc = '0;
    for (int c = 0; c < 300; c++) begin
      if (npop >= 8 && wrap_seen) break;
      bus.avl_ready = 1;
      if (nret < 8 && rq.size() > 0 && $urandom_range(1, 0) == 1) begin
        resp(1);
        nret++;
      end else resp(0);
      vid_de = mfifo.size() > 0;
      if (bus.avl_read_req && bus.avl_ready) begin
        if (prev_acc == 29'h107 && bus.avl_addr == 29'h100)
          wrap_seen = 1;
        prev_acc = bus.avl_addr;
      end
      k = int'(vid_de);
      cycle();
      if (k == 1) begin
        if (npop < 8)
          chk($sformatf("t2_pix[%0d]", npop), 64'(pix_data),
              64'(24'h100 + 24'(npop)));
        npop++;
      end
    end
    vid_de = 0;
    chk("t2_npop", 64'(npop >= 8), 64'd1);
    chk("t2_wrap", 64'(wrap_seen), 64'd1);
    chk("t2_underflow", 64'(underflow), 64'd0);

    // stall a held request, with ram_rdy dropping mid-stall
    done = 0;
    for (int c = 0; c < 100; c++) begin
      bus.avl_ready = 0;
      resp($urandom_range(1, 0) == 1);
      vid_de = mfifo.size() > 0;
      cycle();
      if (m_req) begin
        done = 1;
        break;
      end
    end
    chk("t3_wait_req", 64'(done), 64'd1);
    a0 = m_addr;
    vid_de = 0;
    for (int i = 0; i < 5; i++) begin
      ram_rdy = (i < 3);
      bus.avl_ready = 0;
      resp(0);
      cycle();
      chk($sformatf("t3_hold[%0d]", i),
          {bus.avl_read_req, bus.avl_addr}, {1'b1, a0});
    end
    bus.avl_ready = 1;
    cycle();
    chk("t3_accept", 64'(bus.avl_read_req), 64'd0);
    chk("t3_rq_last", 64'(rq[rq.size()-1]), 64'(a0[23:0]));
    ram_rdy = 1;

    // fill credit, then frame_start with three reads in flight
    done = 0;
    for (int c = 0; c < 100; c++) begin
      bus.avl_ready = 1;
      resp(0);
      vid_de = mfifo.size() > 0;
      cycle();
      if (!m_req && mfifo.size() == 0 && inflight.size() == 4) begin
        done = 1;
        break;
      end
    end
    chk("t4_fill", 64'(done), 64'd1);
    vid_de = 0;
    bus.avl_ready = 0;
    resp(1);
    cycle();
    chk("t4_pre_level", 64'(fifo_level), 64'd1);
    frame_start = 1;
    resp(0);
    cycle();
    frame_start = 0;
    chk("t4_clear", 64'(fifo_level), 64'd0);
    for (int i = 0; i < 3; i++) begin
      bus.rd_data_valid = 1;
      bus.rd_data = {8'($urandom), 24'hAAAAAA};
      void'(rq.pop_front());
      cycle();
      chk($sformatf("t4_drop[%0d]", i), 64'(fifo_level), 64'd0);
    end
    resp(0);
    done = 0;
    for (int c = 0; c < 20; c++) begin
      bus.avl_ready = 1;
      if (bus.avl_read_req) begin
        chk("t4_first_addr", 64'(bus.avl_addr), 64'h100);
        cycle();
        done = 1;
        break;
      end
      cycle();
    end
    chk("t4_accepted", 64'(done), 64'd1);
    bus.avl_ready = 0;
    resp(1);
    cycle();
    resp(0);
    vid_de = 1;
    cycle();
    chk("t4_first_pix", 64'(pix_data), 64'h100);

    // underflow marker and stickiness across frame_start
    vid_de = 1;
    cycle();
    chk("t5_uf", 64'(underflow), 64'd1);
`ifdef FRAME_RD_UNDERFLOW_MARK_EN
    chk("t5_pix", 64'(pix_data), 64'hFF00FF);
`else
    chk("t5_pix", 64'(pix_data), 64'h100);
`endif
    vid_de = 0;
    frame_start = 1;
    cycle();
    frame_start = 0;
    chk("t5_sticky", 64'(underflow), 64'd1);
    cycle();
    chk("t5_sticky2", 64'(underflow), 64'd1);

    // randomized traffic
    use_rand_px = 1;
    reset = 0;
    cycle();
    cycle();
    rq.delete();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(499, 0) != 0);
      ram_rdy = ($urandom_range(15, 0) != 0);
      bus.avl_ready = ($urandom_range(2, 0) != 0);
      frame_start = ($urandom_range(39, 0) == 0);
      vid_de = ($urandom_range(2, 0) == 0);
      resp($urandom_range(1, 0) == 1);
      if (!reset) rq.delete();
      cycle();
    end
    frame_start = 0;
    vid_de = 0;

    // reset with two reads in flight; late returns are ignored
    reset = 0;
    resp(0);
    cycle();
    reset = 1;
    rq.delete();
    ram_rdy = 1;
    bus.avl_ready = 1;
    done = 0;
    for (int c = 0; c < 20; c++) begin
      resp(0);
      cycle();
      if (inflight.size() == 2) begin
        done = 1;
        break;
      end
    end
    chk("t6_two_out", 64'(done), 64'd1);
    reset = 0;
    cycle();
    chk("t6_req", 64'(bus.avl_read_req), 64'd0);
    chk("t6_level", 64'(fifo_level), 64'd0);
    chk("t6_addr", 64'(bus.avl_addr), 64'h100);
    reset = 1;
    ram_rdy = 0;
    for (int i = 0; i < 2; i++) begin
      resp(1);
      cycle();
      chk($sformatf("t6_ignore[%0d]", i), 64'(fifo_level), 64'd0);
    end
    resp(0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
